refill_arbiter: RTL and testbench



---
 rtl/refill_arbiter.sv | 152 +++++++++++++++
 tb/tb_refill_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/refill_arbiter.sv
// Round-robin arbiter sharing the instruction refill port among NUM_REQ requesters.
// Rewrites the downstream ID to the requester index and routes read beats back by ID.
module refill_arbiter #(
    parameter int NUM_REQ          = 2,
    parameter int FETCH_ADDR_WIDTH = 56,
    parameter int ID_WIDTH         = 4,
    parameter int AXI_DATA_WIDTH   = 64
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [NUM_REQ-1:0]                         req_i,
    input  logic [NUM_REQ-1:0]                         type_i,
    input  logic [NUM_REQ-1:0][FETCH_ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_REQ-1:0][ID_WIDTH-1:0]           id_i,
    output logic [NUM_REQ-1:0]                         gnt_o,
    output logic [NUM_REQ-1:0]                         r_valid_o,
    output logic                                       r_last_o,
    output logic [AXI_DATA_WIDTH-1:0]                  r_rdata_o,
    output logic [ID_WIDTH-1:0]                        r_id_o,
    output logic                                       refill_req_o,
    output logic                                       refill_type_o,
    output logic [FETCH_ADDR_WIDTH-1:0]                refill_addr_o,
    output logic [ID_WIDTH-1:0]                        refill_id_o,
    input  logic                                       refill_gnt_i,
    input  logic                                       refill_r_valid_i,
    input  logic                                       refill_r_last_i,
    input  logic [AXI_DATA_WIDTH-1:0]                  refill_r_rdata_i,
    input  logic [ID_WIDTH-1:0]                        refill_r_id_i,
    output logic                                       spurious_o
);

    localparam int                PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ID_WIDTH:0] NUM_REQ_ID = (ID_WIDTH + 1)'(NUM_REQ);

    // Returns {found, index} of the lowest set bit of v.
    function automatic logic [PTR_W:0] first_set(input logic [NUM_REQ-1:0] v);
        logic [PTR_W:0] res;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            res = v[k] ? {1'b1, PTR_W'(k)} : res;
        end
        return res;
    endfunction

    logic                                     r_slot_vld;
    logic                                     r_slot_type;
    logic [FETCH_ADDR_WIDTH-1:0]              r_slot_addr;
    logic [PTR_W-1:0]                         r_slot_idx;
    logic [NUM_REQ-1:0]                       r_outstanding;
    logic [NUM_REQ-1:0][ID_WIDTH-1:0]         r_saved_id;
    logic [PTR_W-1:0]                         r_ptr;

    logic [NUM_REQ-1:0]                       w_elig;
    logic [NUM_REQ-1:0]                       w_upper_mask;
    logic [PTR_W:0]                           w_pick_hi;
    logic [PTR_W:0]                           w_pick_lo;
    logic                                     w_arb_en;
    logic                                     w_found;
    logic [PTR_W-1:0]                         w_win;
    logic [PTR_W-1:0]                         w_ptr_next;
    logic [PTR_W-1:0]                         w_rsp_idx;
    logic                                     w_rsp_hit;

    assign w_elig    = req_i & ~r_outstanding;
    assign w_arb_en  = ~r_slot_vld | refill_gnt_i;
    assign w_rsp_idx = refill_r_id_i[PTR_W-1:0];

    // Round-robin pick: first eligible at or above ptr, else wrap to the lowest eligible.
    always_comb begin
        w_upper_mask = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_upper_mask[k] = (k >= int'(r_ptr));
        end
        w_pick_hi  = first_set(w_elig & w_upper_mask);
        w_pick_lo  = first_set(w_elig);
        w_found    = w_arb_en & w_pick_lo[PTR_W];
        w_win      = w_pick_hi[PTR_W] ? w_pick_hi[PTR_W-1:0] : w_pick_lo[PTR_W-1:0];
        w_ptr_next = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);
    end

    // Grant pulse to the accepted requester.
    always_comb begin
        gnt_o = '0;
        if (w_found) begin
            gnt_o[w_win] = 1'b1;
        end else begin
            gnt_o = '0;
        end
    end

    // A beat belongs to a requester only if its ID is in range and that requester is outstanding.
    always_comb begin
        w_rsp_hit = 1'b0;
        if (refill_r_valid_i && ({1'b0, refill_r_id_i} < NUM_REQ_ID)) begin
            w_rsp_hit = r_outstanding[w_rsp_idx];
        end else begin
            w_rsp_hit = 1'b0;
        end
    end

    // Response demux with the upstream ID restored.
    always_comb begin
        r_valid_o = '0;
        r_id_o    = '0;
        r_last_o  = 1'b0;
        if (w_rsp_hit) begin
            r_valid_o[w_rsp_idx] = 1'b1;
            r_id_o               = r_saved_id[w_rsp_idx];
            r_last_o             = refill_r_last_i;
        end else begin
            r_valid_o = '0;
        end
    end

    assign r_rdata_o     = refill_r_rdata_i;
    assign spurious_o    = refill_r_valid_i & ~w_rsp_hit;
    assign refill_req_o  = r_slot_vld;
    assign refill_type_o = r_slot_type;
    assign refill_addr_o = r_slot_addr;
    assign refill_id_o   = ID_WIDTH'(r_slot_idx);

    // Issue slot, outstanding tracking, saved IDs and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_slot_vld    <= 1'b0;
            r_slot_type   <= 1'b0;
            r_slot_addr   <= '0;
            r_slot_idx    <= '0;
            r_outstanding <= '0;
            r_saved_id    <= '0;
            r_ptr         <= '0;
        end else begin
            if (r_slot_vld && refill_gnt_i) begin
                r_slot_vld <= 1'b0;
            end
            // The winner is never outstanding, so it cannot collide with the freed index.
            if (w_found) begin
                r_slot_vld           <= 1'b1;
                r_slot_type          <= type_i[w_win];
                r_slot_addr          <= addr_i[w_win];
                r_slot_idx           <= w_win;
                r_outstanding[w_win] <= 1'b1;
                r_saved_id[w_win]    <= id_i[w_win];
                r_ptr                <= w_ptr_next;
            end
            if (w_rsp_hit && refill_r_last_i) begin
                r_outstanding[w_rsp_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_refill_arbiter.sv
// Self-checking bench for refill_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the arbiter and memory side.
module tb_refill_arbiter;

    localparam int N  = 2;
    localparam int AW = 56;
    localparam int IW = 4;
    localparam int DW = 64;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [N-1:0]            req_i;
    logic [N-1:0]            type_i;
    logic [N-1:0][AW-1:0]    addr_i;
    logic [N-1:0][IW-1:0]    id_i;
    logic [N-1:0]            gnt_o;
    logic [N-1:0]            r_valid_o;
    logic                    r_last_o;
    logic [DW-1:0]           r_rdata_o;
    logic [IW-1:0]           r_id_o;
    logic                    refill_req_o;
    logic                    refill_type_o;
    logic [AW-1:0]           refill_addr_o;
    logic [IW-1:0]           refill_id_o;
    logic                    refill_gnt_i;
    logic                    refill_r_valid_i;
    logic                    refill_r_last_i;
    logic [DW-1:0]           refill_r_rdata_i;
    logic [IW-1:0]           refill_r_id_i;
    logic                    spurious_o;

    refill_arbiter #(
        .NUM_REQ(N), .FETCH_ADDR_WIDTH(AW), .ID_WIDTH(IW), .AXI_DATA_WIDTH(DW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .type_i(type_i),
        .addr_i(addr_i), .id_i(id_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
        .r_last_o(r_last_o), .r_rdata_o(r_rdata_o), .r_id_o(r_id_o),
        .refill_req_o(refill_req_o), .refill_type_o(refill_type_o),
        .refill_addr_o(refill_addr_o), .refill_id_o(refill_id_o),
        .refill_gnt_i(refill_gnt_i), .refill_r_valid_i(refill_r_valid_i),
        .refill_r_last_i(refill_r_last_i), .refill_r_rdata_i(refill_r_rdata_i),
        .refill_r_id_i(refill_r_id_i), .spurious_o(spurious_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit            m_out [N];
    logic [IW-1:0] m_sid [N];
    bit            m_vld;
    bit            m_type;
    logic [AW-1:0] m_addr;
    int            m_idx;
    int            m_ptr;
    int            e_win;
    bit            e_hit;
    int            e_idx;
    // Memory-side model: granted transactions awaiting beats
    int            pend_idx [$];
    int            pend_left [$];
    int            pick_j = -1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_out[k] = 1'b0;
            m_sid[k] = '0;
        end
        m_vld  = 1'b0;
        m_type = 1'b0;
        m_addr = '0;
        m_idx  = 0;
        m_ptr  = 0;
        pend_idx.delete();
        pend_left.delete();
    endtask

    task automatic idle_inputs();
        req_i            = '0;
        type_i           = '0;
        addr_i           = '0;
        id_i             = '0;
        refill_gnt_i     = 1'b0;
        refill_r_valid_i = 1'b0;
        refill_r_last_i  = 1'b0;
        refill_r_rdata_i = '0;
        refill_r_id_i    = '0;
        pick_j           = -1;
    endtask

    // Mid-cycle: derive expected outputs from the model and compare.
    task automatic settle();
        logic [N-1:0] eg;
        logic [N-1:0] ev;
        int k;
        #4;
        if (!rst_i) begin
            e_idx = int'(refill_r_id_i);
            e_hit = refill_r_valid_i && (e_idx < N) && m_out[e_idx];
            e_win = -1;
            if (!m_vld || refill_gnt_i) begin
                for (int i = 0; i < N; i++) begin
                    k = (m_ptr + i) % N;
                    if (e_win < 0 && req_i[k] && !m_out[k]) e_win = k;
                end
            end
            eg = '0;
            if (e_win >= 0) eg[e_win] = 1'b1;
            ev = '0;
            if (e_hit) ev[e_idx] = 1'b1;
            check_eq("gnt", 64'(gnt_o), 64'(eg));
            check_eq("refill_req", 64'(refill_req_o), 64'(m_vld));
            if (m_vld) begin
                check_eq("refill_type", 64'(refill_type_o), 64'(m_type));
                check_eq("refill_addr", 64'(refill_addr_o), 64'(m_addr));
                check_eq("refill_id", 64'(refill_id_o), 64'(m_idx));
            end
            check_eq("r_valid", 64'(r_valid_o), 64'(ev));
            check_eq("r_last", 64'(r_last_o), 64'(e_hit && refill_r_last_i));
            if (e_hit) check_eq("r_id", 64'(r_id_o), 64'(m_sid[e_idx]));
            check_eq("r_rdata", r_rdata_o, refill_r_rdata_i);
            check_eq("spurious", 64'(spurious_o), 64'(refill_r_valid_i && !e_hit));
        end
    endtask

    // Clock edge: advance model and memory-side bookkeeping.
    task automatic advance();
        @(posedge clk_i);
        if (rst_i) begin
            model_reset();
        end else begin
            if (refill_r_valid_i && pick_j >= 0) begin
                pend_left[pick_j] = pend_left[pick_j] - 1;
                if (pend_left[pick_j] == 0) begin
                    pend_idx.delete(pick_j);
                    pend_left.delete(pick_j);
                end
            end
            if (e_hit && refill_r_last_i) m_out[e_idx] = 1'b0;
            if (m_vld && refill_gnt_i) begin
                pend_idx.push_back(m_idx);
                pend_left.push_back(m_type ? 4 : 1);
                m_vld = 1'b0;
            end
            if (e_win >= 0) begin
                m_vld        = 1'b1;
                m_type       = type_i[e_win];
                m_addr       = addr_i[e_win];
                m_idx        = e_win;
                m_out[e_win] = 1'b1;
                m_sid[e_win] = id_i[e_win];
                m_ptr        = (e_win + 1) % N;
            end
        end
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_req"}, 64'(refill_req_o), 64'd0);
        check_eq({tag, "_gnt"}, 64'(gnt_o), 64'd0);
        check_eq({tag, "_rvalid"}, 64'(r_valid_o), 64'd0);
        check_eq({tag, "_addr"}, 64'(refill_addr_o), 64'd0);
        check_eq({tag, "_id"}, 64'(refill_id_o), 64'd0);
        check_eq({tag, "_type"}, 64'(refill_type_o), 64'd0);
        check_eq({tag, "_rid"}, 64'(r_id_o), 64'd0);
        check_eq({tag, "_spur"}, 64'(spurious_o), 64'd0);
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rst_i = 1'b1;
        settle(); advance();
        settle(); advance();
        rst_i = 1'b0;
        settle();
        check_reset_values("rst");
        advance();

        // Single burst request from requester 0
        req_i[0] = 1'b1; type_i[0] = 1'b1; addr_i[0] = AW'(56'h60); id_i[0] = 4'd5;
        settle();
        check_eq("single_gnt", 64'(gnt_o), 64'd1);
        advance();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            settle();
            check_eq("single_slot_req", 64'(refill_req_o), 64'd1);
            check_eq("single_slot_addr", 64'(refill_addr_o), 64'h60);
            check_eq("single_slot_id", 64'(refill_id_o), 64'd0);
            advance();
        end
        refill_gnt_i = 1'b1;
        settle(); advance();
        idle_inputs();
        refill_r_valid_i = 1'b1; refill_r_id_i = 4'd0; refill_r_rdata_i = 64'hfc;
        settle();
        check_eq("beat1_valid", 64'(r_valid_o), 64'd1);
        check_eq("beat1_rid", 64'(r_id_o), 64'd5);
        check_eq("beat1_last", 64'(r_last_o), 64'd0);
        advance();
        refill_r_rdata_i = 64'h132433d; refill_r_last_i = 1'b1;
        settle();
        check_eq("beat2_last", 64'(r_last_o), 64'd1);
        check_eq("beat2_data", r_rdata_o, 64'h132433d);
        advance();
        refill_r_last_i = 1'b0;
        settle();
        check_eq("after_free_spur", 64'(spurious_o), 64'd1);
        check_eq("after_free_rvalid", 64'(r_valid_o), 64'd0);
        advance();

        // Reset mid-flight with slot valid and outstanding set
        idle_inputs();
        req_i = 2'b11;
        for (int c = 0; c < 3; c++) begin
            settle(); advance();
        end
        idle_inputs();
        rst_i = 1'b1;
        settle(); advance();
        rst_i = 1'b0;
        settle();
        check_reset_values("midrst");
        advance();
        refill_r_valid_i = 1'b1; refill_r_id_i = 4'd0;
        settle();
        check_eq("post_rst_spur", 64'(spurious_o), 64'd1);
        advance();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            idle_inputs();
            rst_i = ($urandom_range(399, 0) == 0);
            req_i = N'($urandom);
            type_i = N'($urandom);
            for (int k = 0; k < N; k++) begin
                addr_i[k] = AW'({$urandom(), $urandom()});
                id_i[k]   = IW'($urandom);
            end
            refill_gnt_i     = ($urandom_range(2, 0) != 0);
            refill_r_rdata_i = {$urandom(), $urandom()};
            refill_r_id_i    = IW'($urandom);
            if (pend_idx.size() > 0 && $urandom_range(3, 0) != 0) begin
                pick_j           = int'($urandom_range(pend_idx.size() - 1, 0));
                refill_r_valid_i = 1'b1;
                refill_r_id_i    = IW'(pend_idx[pick_j]);
                refill_r_last_i  = (pend_left[pick_j] == 1);
            end else if ($urandom_range(7, 0) == 0) begin
                refill_r_valid_i = 1'b1;
                refill_r_id_i    = IW'($urandom_range(15, N));
                refill_r_last_i  = 1'($urandom);
            end
            settle();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
